// File: rtl/ttl_sched_pkg.sv
// Shared types for the TTL event scheduler.
// Event record, scheduler state and a popcount helper.
package ttl_sched_pkg;

    localparam int TTL_SUBSAMPLES = 8;
    localparam int TTL_TS_W       = 64;

    typedef struct packed {
        logic [TTL_TS_W-1:0]       ts;
        logic [TTL_SUBSAMPLES-1:0] pattern;
    } ttl_event_t;

    typedef enum logic {
        S_IDLE,
        S_ARMED
    } sched_state_t;

    function automatic logic [3:0] f_popcount8(input logic [TTL_SUBSAMPLES-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < TTL_SUBSAMPLES; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/ttl_event_fifo.sv
// First-word-fall-through event queue for the TTL scheduler.
// Pointers carry a wrap bit so full/empty come from a pointer compare.
module ttl_event_fifo
    import ttl_sched_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_push,
    input  ttl_event_t i_din,
    input  logic       i_pop,
    output logic       o_full,
    output logic       o_empty,
    output ttl_event_t o_head,
    output logic [AW:0] o_count
);

    logic [AW:0] r_wr;
    logic [AW:0] r_rd;
    ttl_event_t  r_mem [DEPTH];
    logic        w_wr_en;
    logic        w_rd_en;

    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                     (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_count = r_wr - r_rd;
    assign o_head  = r_mem[r_rd[AW-1:0]];

    assign w_wr_en = i_push && !o_full;
    assign w_rd_en = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_wr_en) r_wr <= r_wr + 1'b1;
            if (w_rd_en) r_rd <= r_rd + 1'b1;
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/ttl_event_scheduler.sv
// Timed sequencer for one TTLx8 channel: fires queued events at their timestamp.
// Optional rising-edge counter enabled by defining TTL_EDGE_COUNT_EN.
module ttl_event_scheduler
    import ttl_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int TS_W       = TTL_TS_W
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [TS_W-1:0] counter,
    input  logic            ev_valid,
    output logic            ev_ready,
    input  logic [TS_W-1:0] ev_time,
    input  logic [7:0]      ev_pattern,
    input  logic            override_en,
    input  logic            override_level,
    input  logic            clear_err,
    output logic [7:0]      pattern_out,
    output logic            queue_empty,
    output logic            late_err,
    output logic            overflow_err
`ifdef TTL_EDGE_COUNT_EN
    ,
    input  logic            edge_count_clr,
    output logic [31:0]     edge_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    sched_state_t r_state;
    sched_state_t w_state_nx;

    logic       r_up;
    logic [7:0] r_pat;
    logic       r_last_level;
    logic       r_late;
    logic       r_ovf;

    ttl_event_t  w_din;
    ttl_event_t  w_head;
    logic        w_full;
    logic        w_empty;
    logic [AW:0] w_count;
    logic        w_push;
    logic        w_pop;
    logic        w_fire;
    logic        w_late;
    logic        w_armed;
    logic [7:0]  w_next_pat;

    assign w_din    = '{ts: ev_time, pattern: ev_pattern};
    assign ev_ready = r_up && !w_full;
    assign w_push   = ev_valid && ev_ready;

    ttl_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign w_armed = (r_state == S_ARMED) && !w_empty;
    assign w_fire  = w_armed && (w_head.ts == counter);
    assign w_late  = w_armed && (w_head.ts < counter);
    assign w_pop   = w_fire || w_late;

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_push) w_state_nx = S_ARMED;
            end
            S_ARMED: begin
                if (w_pop && (w_count == (AW+1)'(1)) && !w_push)
                    w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Override masks the output only; firing and last_level continue underneath.
    always_comb begin
        w_next_pat = {TTL_SUBSAMPLES{r_last_level}};
        if (w_fire)      w_next_pat = w_head.pattern;
        if (override_en) w_next_pat = {TTL_SUBSAMPLES{override_level}};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_up         <= 1'b0;
            r_pat        <= '0;
            r_last_level <= 1'b0;
            r_late       <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_up  <= 1'b1;
            r_pat <= w_next_pat;
            if (w_fire) r_last_level <= w_head.pattern[7];
            r_late <= w_late || (r_late && !clear_err);
            r_ovf  <= (ev_valid && w_full) || (r_ovf && !clear_err);
        end
    end

    assign pattern_out  = r_pat;
    assign queue_empty  = w_empty;
    assign late_err     = r_late;
    assign overflow_err = r_ovf;

`ifdef TTL_EDGE_COUNT_EN
    logic [31:0] r_edges;
    logic [7:0]  w_rise;

    assign w_rise = w_next_pat & ~{w_next_pat[6:0], r_pat[7]};

    always_ff @(posedge clk) begin
        if (!resetn || edge_count_clr) begin
            r_edges <= '0;
        end else if (r_edges != 32'hFFFF_FFFF) begin
            if ({28'd0, f_popcount8(w_rise)} > (32'hFFFF_FFFF - r_edges))
                r_edges <= 32'hFFFF_FFFF;
            else
                r_edges <= r_edges + {28'd0, f_popcount8(w_rise)};
        end
    end

    assign edge_count = r_edges;
`endif

endmodule

// File: tb/tb_ttl_event_scheduler.sv
// Randomized bench for ttl_event_scheduler against a queue-based model.
// Directed scenarios first, then random traffic with overrides and resets.
module tb_ttl_event_scheduler;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic [63:0] counter;
    logic        ev_valid;
    logic        ev_ready;
    logic [63:0] ev_time;
    logic [7:0]  ev_pattern;
    logic        override_en;
    logic        override_level;
    logic        clear_err;
    logic [7:0]  pattern_out;
    logic        queue_empty;
    logic        late_err;
    logic        overflow_err;
`ifdef TTL_EDGE_COUNT_EN
    logic        edge_count_clr;
    logic [31:0] edge_count;
`endif

    ttl_event_scheduler #(
        .FIFO_DEPTH (DEPTH),
        .TS_W       (64)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .counter        (counter),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_time        (ev_time),
        .ev_pattern     (ev_pattern),
        .override_en    (override_en),
        .override_level (override_level),
        .clear_err      (clear_err),
        .pattern_out    (pattern_out),
        .queue_empty    (queue_empty),
        .late_err       (late_err),
        .overflow_err   (overflow_err)
`ifdef TTL_EDGE_COUNT_EN
        ,
        .edge_count_clr (edge_count_clr),
        .edge_count     (edge_count)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h cnt=%0d", tag, got, exp, counter);
        end
    endtask

    // Reference model: a plain queue of pending events and the visible outputs.
    longint unsigned m_t[$];
    byte unsigned    m_p[$];
    logic [7:0]      m_out;
    logic            m_last;
    logic            m_late;
    logic            m_ovf;
    logic            m_up;
    longint unsigned m_edges;
    longint unsigned cnt;

    function automatic int popc(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic step();
        logic       full;
        logic       ready;
        logic [7:0] nxt;
        logic       fire;
        logic       late;
        logic [7:0] hp;
        fire = 1'b0;
        late = 1'b0;
        hp   = 8'h00;
        if (!resetn) begin
            m_t.delete();
            m_p.delete();
            m_out = 8'h00; m_last = 1'b0;
            m_late = 1'b0; m_ovf = 1'b0; m_up = 1'b0;
            m_edges = 0;
        end else begin
            full  = (m_t.size() == DEPTH);
            ready = m_up && !full;
            if (m_t.size() > 0) begin
                hp = m_p[0];
                if (m_t[0] == cnt) fire = 1'b1;
                else if (m_t[0] < cnt) late = 1'b1;
                if (fire || late) begin
                    void'(m_t.pop_front());
                    void'(m_p.pop_front());
                end
            end
            if (override_en) nxt = {8{override_level}};
            else if (fire)   nxt = hp;
            else             nxt = {8{m_last}};
`ifdef TTL_EDGE_COUNT_EN
            if (edge_count_clr) m_edges = 0;
            else begin
                m_edges += popc(nxt & ~{nxt[6:0], m_out[7]});
                if (m_edges > 64'hFFFF_FFFF) m_edges = 64'hFFFF_FFFF;
            end
`endif
            m_out = nxt;
            if (fire) m_last = hp[7];
            m_late = late || (m_late && !clear_err);
            m_ovf  = (ev_valid && full) || (m_ovf && !clear_err);
            if (ev_valid && ready) begin
                m_t.push_back(ev_time);
                m_p.push_back(ev_pattern);
            end
            m_up = 1'b1;
        end
        @(posedge clk);
        #1;
        cnt++;
        counter = cnt;
        chk("pattern_out", pattern_out, m_out);
        chk("ev_ready", ev_ready, m_up && (m_t.size() < DEPTH));
        chk("queue_empty", queue_empty, m_t.size() == 0);
        chk("late_err", late_err, m_late);
        chk("overflow_err", overflow_err, m_ovf);
`ifdef TTL_EDGE_COUNT_EN
        chk("edge_count", edge_count, m_edges);
`endif
    endtask

    task automatic idle();
        ev_valid  = 1'b0;
        clear_err = 1'b0;
        step();
    endtask

    task automatic idle_until(input longint unsigned n);
        while (cnt < n) idle();
    endtask

    task automatic push(input longint unsigned t, input logic [7:0] p);
        ev_valid   = 1'b1;
        ev_time    = t;
        ev_pattern = p;
        step();
        ev_valid   = 1'b0;
    endtask

    initial begin
        cnt = 0;
        counter = '0;
        resetn = 1'b0;
        ev_valid = 1'b1;
        ev_time = 64'd5;
        ev_pattern = 8'hAA;
        override_en = 1'b0;
        override_level = 1'b0;
        clear_err = 1'b0;
`ifdef TTL_EDGE_COUNT_EN
        edge_count_clr = 1'b0;
`endif
        repeat (3) step();
        chk("rst_pattern", pattern_out, 8'h00);
        chk("rst_ready", ev_ready, 1'b0);
        chk("rst_empty", queue_empty, 1'b1);
        resetn = 1'b1;
        ev_valid = 1'b0;
        step();
        chk("ready_after_rst", ev_ready, 1'b1);
        chk("no_write_in_rst", queue_empty, 1'b1);

        idle_until(50);
        push(100, 8'hF0);
        idle_until(101);
        chk("single_fire", pattern_out, 8'hF0);
        idle();
        chk("single_hold", pattern_out, 8'hFF);
        chk("single_empty", queue_empty, 1'b1);

        push(200, 8'h0F);
        push(201, 8'h00);
        idle_until(201);
        chk("b2b_first", pattern_out, 8'h0F);
        idle();
        chk("b2b_second", pattern_out, 8'h00);
        idle();
        chk("b2b_hold", pattern_out, 8'h00);
        chk("b2b_no_late", late_err, 1'b0);

        idle_until(210);
        push(10, 8'hFF);
        idle();
        chk("late_flag", late_err, 1'b1);
        chk("late_out", pattern_out, 8'h00);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("late_clear", late_err, 1'b0);

        push(300, 8'hAA);
        push(300, 8'h55);
        idle_until(301);
        chk("dup_fire", pattern_out, 8'hAA);
        idle();
        chk("dup_late", late_err, 1'b1);
        chk("dup_hold", pattern_out, 8'hFF);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;

        push(500, 8'h00);
        idle_until(495);
        override_en = 1'b1;
        override_level = 1'b1;
        idle_until(502);
        chk("ovr_forced", pattern_out, 8'hFF);
        idle_until(510);
        override_en = 1'b0;
        idle();
        chk("ovr_release", pattern_out, 8'h00);

`ifdef TTL_EDGE_COUNT_EN
        push(520, 8'b0101_0101);
        idle_until(520);
        begin
            logic [31:0] e0;
            e0 = m_edges[31:0];
            idle();
            chk("edge_plus4", edge_count, e0 + 32'd4);
        end
`endif

        idle_until(600);
        for (int i = 0; i < DEPTH; i++) push(1000 + i, 8'(i * 17));
        chk("full_ready", ev_ready, 1'b0);
        push(2000, 8'h11);
        chk("overflow", overflow_err, 1'b1);
        idle_until(1001);
        chk("full_first", pattern_out, 8'h00);
        chk("full_ready_back", ev_ready, 1'b1);
        idle_until(1020);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            ev_valid   = ($urandom_range(0, 1) == 1);
            ev_time    = cnt + $urandom_range(0, 28) - 4;
            ev_pattern = 8'($urandom);
            clear_err  = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 19) == 0) override_en = ~override_en;
            override_level = 1'($urandom);
`ifdef TTL_EDGE_COUNT_EN
            edge_count_clr = ($urandom_range(0, 63) == 0);
`endif
            resetn = ($urandom_range(0, 499) != 0);
            step();
        end
        resetn = 1'b1;
        override_en = 1'b0;
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
